// File: rtl/clk_proc_pkg.sv
// Shared types and default timing constants for the processor clock generator.
package clk_proc_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        HALTED       = 2'd3
    } clk_state_t;

    // 1 Hz processor clock from a 50 MHz board clock; 10 ms debounce window.
    localparam int DEF_DIV_HALF     = 25000000;
    localparam int DEF_DEBOUNCE_CYC = 500000;

endpackage

// File: rtl/gerador_clock_proc_debouncer.sv
// Push-button debouncer: 2-FF synchronizer, stability counter, and single-cycle
// press/release pulses. The raw button is active-low, so a high level means released.
module debouncer
    import clk_proc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao,
    output logic evt_press,
    output logic evt_release
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          done;

    assign differ = (sync[1] != level);
    // The level flips on the DEBOUNCE_CYC-th consecutive differing cycle.
    assign done   = differ && (cnt == CW'(DEBOUNCE_CYC - 1));

    assign evt_press   = done && !sync[1];
    assign evt_release = done &&  sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], botao};
            if (done) begin
                level <= sync[1];
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gerador_clock_proc.sv
// Processor clock generator: divides clk_rapido and gates rising edges with HALT/WAIT.
// Optional single-step mode is enabled by defining STEP_MODE_EN (adds the passo input).
module gerador_clock_proc
    import clk_proc_pkg::*;
#(
    parameter int DIV_HALF     = DEF_DIV_HALF,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic        clk_rapido,
    input  logic        reset,
    input  logic        HALT,
    input  logic        WAIT,
    input  logic        botao,
`ifdef STEP_MODE_EN
    input  logic        passo,
`endif
    output logic        clk,
    output logic        parado,
    output logic        aguardando,
    output logic [31:0] ciclos
);

    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    clk_state_t    state, state_n;
    logic [DW-1:0] cnt, cnt_n;
    logic          clk_n;
    logic [31:0]   ciclos_n;
    logic          evt_press, evt_release;
    logic          terminal, pending, go;

    debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debouncer (
        .clk        (clk_rapido),
        .rst_n      (reset),
        .botao      (botao),
        .evt_press  (evt_press),
        .evt_release(evt_release)
    );

    assign terminal = (cnt == DW'(DIV_HALF - 1));
    assign pending  = (state == RUN) && terminal && !clk;

`ifdef STEP_MODE_EN
    // Step mode parks at the pending rise until a full press+release is seen.
    logic armed, armed_n;

    assign go = pending && (!passo || (armed && evt_release));

    always_comb begin
        armed_n = 1'b0;
        if (pending && passo)
            armed_n = armed || evt_press;
    end

    always_ff @(posedge clk_rapido or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= armed_n;
    end
`else
    assign go = pending;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        clk_n    = clk;
        ciclos_n = ciclos;
        case (state)
            RUN: begin
                if (terminal && clk) begin
                    clk_n = 1'b0;
                    cnt_n = '0;
                end else if (go) begin
                    if (HALT) begin
                        state_n = HALTED;
                    end else if (WAIT) begin
                        state_n = WAIT_PRESS;
                        cnt_n   = '0;
                    end else begin
                        clk_n    = 1'b1;
                        cnt_n    = '0;
                        ciclos_n = ciclos + 32'd1;
                    end
                end else if (!pending) begin
                    cnt_n = cnt + DW'(1);
                end
            end
            WAIT_PRESS: begin
                if (evt_press) state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (evt_release) begin
                    state_n  = RUN;
                    clk_n    = 1'b1;
                    cnt_n    = '0;
                    ciclos_n = ciclos + 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_rapido or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            cnt    <= '0;
            clk    <= 1'b0;
            ciclos <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            clk    <= clk_n;
            ciclos <= ciclos_n;
        end
    end

    assign parado     = (state == HALTED);
    assign aguardando = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_gerador_clock_proc.sv
// Directed bench for gerador_clock_proc with DIV_HALF=2, DEBOUNCE_CYC=4.
module tb_gerador_clock_proc;

    logic        clk_rapido = 1'b0;
    logic        reset      = 1'b0;
    logic        HALT       = 1'b0;
    logic        WAIT       = 1'b0;
    logic        botao      = 1'b1;
`ifdef STEP_MODE_EN
    logic        passo      = 1'b0;
`endif
    logic        clk;
    logic        parado;
    logic        aguardando;
    logic [31:0] ciclos;

    int checks = 0;
    int errors = 0;

    gerador_clock_proc #(.DIV_HALF(2), .DEBOUNCE_CYC(4)) dut (
        .clk_rapido(clk_rapido),
        .reset     (reset),
        .HALT      (HALT),
        .WAIT      (WAIT),
        .botao     (botao),
`ifdef STEP_MODE_EN
        .passo     (passo),
`endif
        .clk       (clk),
        .parado    (parado),
        .aguardando(aguardando),
        .ciclos    (ciclos)
    );

    always #5 clk_rapido = ~clk_rapido;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n board-clock edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_rapido);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_clk", {31'd0, clk}, 32'd0);
        chk("rst_ciclos", ciclos, 32'd0);
        chk("rst_parado", {31'd0, parado}, 32'd0);
        chk("rst_aguard", {31'd0, aguardando}, 32'd0);

        // 1: free run
        reset = 1'b1;
        tick(1); chk("run_e1_clk", {31'd0, clk}, 32'd0);
        tick(1); chk("run_e2_clk", {31'd0, clk}, 32'd1);
                 chk("run_e2_ciclos", ciclos, 32'd1);
        tick(2); chk("run_e4_clk", {31'd0, clk}, 32'd0);
        tick(2); chk("run_e6_clk", {31'd0, clk}, 32'd1);
        tick(4); chk("run_e10_ciclos", ciclos, 32'd3);
                 chk("run_e10_clk", {31'd0, clk}, 32'd1);

        // 2: WAIT before first rise, then press 10 / release
        do_reset();
        WAIT = 1'b1;
        tick(2);  chk("wait_aguard", {31'd0, aguardando}, 32'd1);
                  chk("wait_clk", {31'd0, clk}, 32'd0);
        tick(20); chk("wait_hold_clk", {31'd0, clk}, 32'd0);
        botao = 1'b0;
        tick(10); chk("wait_pressed_clk", {31'd0, clk}, 32'd0);
                  chk("wait_pressed_aguard", {31'd0, aguardando}, 32'd1);
        botao = 1'b1;
        tick(5);  chk("wait_rel5_clk", {31'd0, clk}, 32'd0);
        tick(1);  chk("wait_rel6_clk", {31'd0, clk}, 32'd1);
                  chk("wait_rel6_ciclos", ciclos, 32'd1);
                  chk("wait_rel6_aguard", {31'd0, aguardando}, 32'd0);
        WAIT = 1'b0;

        // 4: bounces of 3 cycles do not count; 4 stable cycles do
        do_reset();
        WAIT = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            botao = 1'b0; tick(3);
            botao = 1'b1; tick(3);
        end
        chk("bounce_clk", {31'd0, clk}, 32'd0);
        chk("bounce_aguard", {31'd0, aguardando}, 32'd1);
        chk("bounce_ciclos", ciclos, 32'd0);
        botao = 1'b0; tick(4);
        botao = 1'b1;
        tick(5); chk("bounce_rel5_clk", {31'd0, clk}, 32'd0);
        tick(1); chk("bounce_rel6_clk", {31'd0, clk}, 32'd1);
                 chk("bounce_ciclos1", ciclos, 32'd1);
        WAIT = 1'b0;

        // 3: HALT and WAIT together at a pending rise
        do_reset();
        tick(2); chk("halt_pre_ciclos", ciclos, 32'd1);
        HALT = 1'b1; WAIT = 1'b1;
        tick(4); chk("halt_parado", {31'd0, parado}, 32'd1);
                 chk("halt_aguard", {31'd0, aguardando}, 32'd0);
                 chk("halt_clk", {31'd0, clk}, 32'd0);
        HALT = 1'b0; WAIT = 1'b0;
        botao = 1'b0; tick(10); botao = 1'b1;
        tick(1000);
        chk("halt_1000_clk", {31'd0, clk}, 32'd0);
        chk("halt_1000_ciclos", ciclos, 32'd1);
        chk("halt_1000_parado", {31'd0, parado}, 32'd1);

        // 5a: async reset while HALTED
        reset = 1'b0; #2;
        chk("rst_halt_parado", {31'd0, parado}, 32'd0);
        chk("rst_halt_ciclos", ciclos, 32'd0);
        chk("rst_halt_clk", {31'd0, clk}, 32'd0);
        tick(1); reset = 1'b1;
        tick(2); chk("rst_halt_run_clk", {31'd0, clk}, 32'd1);
                 chk("rst_halt_run_ciclos", ciclos, 32'd1);

        // 5b: async reset while WAIT_RELEASE
        WAIT = 1'b1;
        tick(4); chk("wr_aguard", {31'd0, aguardando}, 32'd1);
        botao = 1'b0;
        tick(10);
        reset = 1'b0; #2;
        chk("rst_wr_aguard", {31'd0, aguardando}, 32'd0);
        chk("rst_wr_ciclos", ciclos, 32'd0);
        chk("rst_wr_clk", {31'd0, clk}, 32'd0);
        chk("rst_wr_parado", {31'd0, parado}, 32'd0);
        botao = 1'b1; WAIT = 1'b0;
        tick(2); reset = 1'b1;
        tick(2); chk("rst_wr_run_clk", {31'd0, clk}, 32'd1);
                 chk("rst_wr_run_ciclos", ciclos, 32'd1);

`ifdef STEP_MODE_EN
        // 6: single-step
        do_reset();
        passo = 1'b1;
        tick(20); chk("step_idle_clk", {31'd0, clk}, 32'd0);
                  chk("step_idle_ciclos", ciclos, 32'd0);
        for (int s = 1; s <= 2; s++) begin
            botao = 1'b0; tick(8);
            botao = 1'b1;
            tick(5); chk("step_rel5_clk", {31'd0, clk}, 32'd0);
            tick(1); chk("step_rel6_clk", {31'd0, clk}, 32'd1);
                     chk("step_ciclos", ciclos, 32'(s));
            tick(20); chk("step_park_clk", {31'd0, clk}, 32'd0);
                      chk("step_park_ciclos", ciclos, 32'(s));
        end
        passo = 1'b0;
        tick(1); chk("step_resume_clk", {31'd0, clk}, 32'd1);
                 chk("step_resume_ciclos", ciclos, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gerador_clock_proc.md
Name: gerador_clock_proc

Overview:
- Generates the processor clock `clk` from the board clock `clk_rapido` and gates it with the processor's `HALT` and `WAIT` outputs.
- Sits directly upstream of the processor core.
- `HALT` freezes the processor permanently, until reset.
- `WAIT` (syscall IN) stalls the processor until the user confirms with a debounced push-button; the pending instruction then commits with the current switch values.

Parameters:
- DIV_HALF, 25000000: `clk_rapido` cycles per `clk` half-period (≥1); 1 Hz at 50 MHz.
- DEBOUNCE_CYC, 500000: consecutive stable `clk_rapido` cycles required to accept a new button level (≥1).

Ports:
- clk_rapido  in  1  board clock; the only clock of the block.
- reset  in  1  asynchronous, active-low reset.
- HALT  in  1  processor halt request; combinational from the current instruction.
- WAIT  in  1  processor wait request (syscall IN); combinational from the current instruction.
- botao  in  1  confirm push-button, raw, active-low (KEY of DE2-115).
- clk  out  1  processor clock, registered.
- parado  out  1  high in HALTED state.
- aguardando  out  1  high in WAIT_PRESS or WAIT_RELEASE state.
- ciclos  out  32  count of `clk` rising edges produced since reset.

Behaviour:
- Reset (asynchronous, while `reset`=0):
  - `clk`=0, divider count=0, state=RUN, `ciclos`=0, `parado`=0, `aguardando`=0.
  - Debounced button = released; synchronizer flops = 1.
- Divider:
  - Count width is $clog2(DIV_HALF), minimum 1.
  - "Terminal" means count == DIV_HALF-1.
  - In RUN, each cycle: if terminal, count<=0 and `clk` toggles; otherwise count increments.
  - Result: `clk` period = 2*DIV_HALF cycles, duty 50%.
- Gating: HALT and WAIT are sampled only at a terminal cycle while `clk`=0, i.e. on a pending rising edge.
  - HALT=1 → state HALTED. The rising edge is suppressed and `clk` stays 0. HALT has priority over WAIT.
  - WAIT=1 → state WAIT_PRESS. The rising edge is suppressed, `clk` stays 0, count<=0.
  - Otherwise, the rising edge occurs and `ciclos`<=`ciclos`+1 (wraps modulo 2^32).
  - Falling edges are never gated.
- States:
  - RUN: normal divider operation.
  - WAIT_PRESS: divider frozen. On the debounced press event (released→pressed) → WAIT_RELEASE.
  - WAIT_RELEASE: divider frozen. On the debounced release event, in the same cycle: `clk`<=1, count<=0, `ciclos`+1, state → RUN. The next falling edge follows DIV_HALF cycles later.
  - HALTED: absorbing; only reset exits it.
- Debounce:
  - 2-FF synchronizer on `botao`, then a stability counter.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any bounce restarts the counter.
  - Press/release events are single-cycle pulses.
  - Events in RUN or HALTED are discarded, not latched.
- Outputs:
  - `parado` and `aguardando` are decoded from the registered state and change in the same cycle as the state register.
  - `clk` is driven straight from a flop and is glitch-free.
- Reset mid-operation (any state, including mid-debounce): immediate return to reset values; no partial edge.

Optional Feature:
- STEP_MODE_EN defined:
  - Adds input `passo` (1 bit, switch, active-high).
  - While `passo`=1 in RUN, the divider stops at the pending-rise point and waits for a debounced press+release.
  - The release produces exactly one rising edge, subject to the same HALT/WAIT checks.
  - The falling edge then follows after DIV_HALF cycles.
  - WAIT still requires its own separate press+release.
- STEP_MODE_EN undefined: no `passo` port; the behaviour is exactly as above.

Decomposition:
- Package `clk_proc_pkg`:
  - State enum: RUN, WAIT_PRESS, WAIT_RELEASE, HALTED.
  - Default parameter constants.
- One sub-module `debouncer` (parameter DEBOUNCE_CYC):
  - Synchronizer, stability counter, debounced level.
  - `evt_press` / `evt_release` pulses.

Test Plan:
All scenarios use DIV_HALF=2, DEBOUNCE_CYC=4.
1. Reset released, HALT=WAIT=0 → `clk` rises after the 2nd `clk_rapido` edge, falls after the 4th, rises after the 6th; `ciclos`=3 after 10 edges.
2. WAIT=1 before the first rise → `clk` stays 0, `aguardando`=1. Then `botao`=0 for 10 cycles and `botao`=1 for 10 cycles → exactly one rise about 6 cycles after the release (2-FF + 4), `ciclos`=1, `aguardando`=0.
3. HALT=1 and WAIT=1 together at a pending rise → `parado`=1, `aguardando`=0; `clk` stays 0 for 1000 cycles; `ciclos` is frozen.
4. In WAIT_PRESS, `botao` low pulses of 3 cycles, repeated → no state change; a 4-cycle stable low → WAIT_RELEASE.
5. `reset`=0 asserted during WAIT_RELEASE and during HALTED → `clk`=0, `ciclos`=0, `parado`=`aguardando`=0 asynchronously; normal run after release.
6. STEP_MODE_EN, `passo`=1 → no rise without the button; each press+release gives exactly one rise and `ciclos`+1; `passo`=0 resumes free-running.
